// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: register file behind an I2C slave, with auto-incrementing pointer
// Ports: Clk/Rst (sync, active-high); Start_det/Stop_det/rw_flag bus events from the slave;
//        Wr_vld/Wr_data bytes received; Rd_req/Rd_vld/Rd_data bytes to transmit;
//        Disp_data live copy of reg[DISP_IDX]; Busy high outside IDLE.
// Macro I2C_REG_CTRL_WRAP_EN: pointer wraps modulo 2^AW instead of saturating.
module i2c_reg_ctrl #(
    parameter int AW       = 4,
    parameter int DISP_IDX = 0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start_det,
    input  logic       Stop_det,
    input  logic       rw_flag,
    input  logic       Wr_vld,
    input  logic [7:0] Wr_data,
    input  logic       Rd_req,
    output logic       Rd_vld,
    output logic [7:0] Rd_data,
    output logic [7:0] Disp_data,
    output logic       Busy
);
    typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;
    state_t          r_state, w_nxt;
    logic [7:0]      r_regs [2**AW];
    logic [AW-1:0]   r_ptr, w_ptr_nxt;
    logic            r_sat, w_sat_set;
    logic [7:0]      r_rd_data;
    logic            r_rd_vld;
    logic            w_quiet, w_addr_ld, w_reg_wr, w_rd;
    // Bus events outrank data strobes; a strobe coinciding with START/STOP is dropped.
    assign w_quiet   = !Stop_det && !Start_det;
    assign w_addr_ld = w_quiet && Wr_vld && r_state == ADDR;
    assign w_reg_wr  = w_quiet && Wr_vld && r_state == WRITE && !r_sat;
    assign w_rd      = w_quiet && Rd_req && r_state == READ;
`ifdef I2C_REG_CTRL_WRAP_EN
    assign w_ptr_nxt = r_ptr + 1'b1;
    assign w_sat_set = 1'b0;
`else
    // r_sat blocks further writes once the last register has been written.
    assign w_ptr_nxt = (&r_ptr) ? r_ptr : r_ptr + 1'b1;
    assign w_sat_set = &r_ptr;
`endif
    always_comb begin
        w_nxt = r_state;
        if (Stop_det)
            w_nxt = IDLE;
        else if (Start_det)
            w_nxt = rw_flag ? READ : ADDR;
        else if (w_addr_ld)
            w_nxt = WRITE;
    end
    always_ff @(posedge Clk) begin
        if (Rst)
            r_state <= IDLE;
        else
            r_state <= w_nxt;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr     <= '0;
            r_sat     <= 1'b0;
            r_rd_data <= 8'h00;
            r_rd_vld  <= 1'b0;
            for (int i = 0; i < 2**AW; i++)
                r_regs[i] <= 8'h00;
        end else begin
            r_rd_vld <= w_rd;
            if (w_addr_ld) begin
                r_ptr <= Wr_data[AW-1:0];
                r_sat <= 1'b0;
            end else if (w_reg_wr) begin
                r_regs[r_ptr] <= Wr_data;
                r_ptr         <= w_ptr_nxt;
                r_sat         <= w_sat_set;
            end else if (w_rd) begin
                r_rd_data <= r_regs[r_ptr];
                r_ptr     <= w_ptr_nxt;
            end
        end
    end
    assign Rd_vld    = r_rd_vld;
    assign Rd_data   = r_rd_data;
    assign Disp_data = r_regs[DISP_IDX];
    assign Busy      = r_state != IDLE;
endmodule
